// File: rtl/neuron_pkg.sv
// Shared types and helpers for the neuron training (backprop) block.
//   data_t    : signed 8-bit weight / bias / error / input value
//   preact_t  : signed 18-bit forward pre-activation
//   prod_t    : signed 16-bit error * input product
//   bp_state_e: update sequencer states
//   sat8      : clamp a signed 17-bit value into the signed 8-bit range
package neuron_pkg;

  typedef logic signed [7:0]  data_t;
  typedef logic signed [17:0] preact_t;
  typedef logic signed [15:0] prod_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRAD  = 2'd1,
    DRAIN = 2'd2,
    BIAS  = 2'd3
  } bp_state_e;

  function automatic data_t sat8(input logic signed [16:0] v);
    if (v > 17'sd127) begin
      return data_t'(8'h7f);
    end else if (v < -17'sd128) begin
      return data_t'(8'h80);
    end else begin
      return data_t'(v[7:0]);
    end
  endfunction

endpackage

// File: rtl/neuron_backprop_grad_step.sv
// Two-stage gradient step pipeline for one weight per accepted beat.
//   S1: registers prod = delta * x together with the beat index.
//   S2: step = prod >>> LR_SHIFT (floor), w_new = sat8(w[idx] - step).
//       wr_* is the combinational S2 result the owner writes into its
//       weight file; upd_* is the same result registered one cycle later.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid, in_idx    accepted beat and its index
//   delta, x            gated error and input value of that beat
//   s1_idx / w_cur      owner returns the current weight at s1_idx
//   wr_en/idx/data      weight write for this cycle
//   upd_valid/idx/w     registered one-cycle update report
module grad_step
  import neuron_pkg::*;
#(
  parameter int IDX_W    = 2,
  parameter int LR_SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  input  data_t            delta,
  input  data_t            x,
  output logic [IDX_W-1:0] s1_idx,
  input  data_t            w_cur,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_idx,
  output data_t            wr_data,
  output logic             upd_valid,
  output logic [IDX_W-1:0] upd_idx,
  output data_t            upd_w
);

  logic             s1_valid_q;
  prod_t            s1_prod_q;
  logic [IDX_W-1:0] s1_idx_q;
  prod_t            step;
  logic signed [16:0] diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_prod_q  <= '0;
      s1_idx_q   <= '0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_prod_q <= prod_t'(delta) * prod_t'(x);
        s1_idx_q  <= in_idx;
      end
    end
  end

  // Arithmetic shift floors toward minus infinity (-1 >>> 4 = -1).
  always_comb begin
    step    = s1_prod_q >>> LR_SHIFT;
    diff    = {{9{w_cur[7]}}, w_cur} - {step[15], step};
    wr_en   = s1_valid_q;
    wr_idx  = s1_idx_q;
    wr_data = sat8(diff);
  end

  assign s1_idx = s1_idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid <= 1'b0;
      upd_idx   <= '0;
      upd_w     <= '0;
    end else begin
      upd_valid <= wr_en;
      if (wr_en) begin
        upd_idx <= wr_idx;
        upd_w   <= wr_data;
      end
    end
  end

endmodule

// File: rtl/neuron_backprop.sv
// Training-direction neuron: owns N_INPUTS signed 8-bit weights and a bias,
// serves them to the forward path, and applies one ReLU-gated, shift-scaled
// gradient step per error sample (every weight, then the bias).
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   start_valid/start_ready, err, pre_act   error sample handshake
//   x_valid/x_ready, x            input-vector beats, index order 0..N-1
//   w_ld_en, w_ld_idx, w_ld_data, b_ld_en   preloads (IDLE only)
//   w_rd_idx, w_rd_data, bias_out combinational parameter read
//   upd_valid, upd_idx, upd_w     per-weight update pulse
//   done                          pulses in the cycle the bias commits
//   state_dbg                     current sequencer state
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; ready never depends on valid, and start_ready/x_ready depend
// only on registered state.
module neuron_backprop
  import neuron_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int LR_SHIFT = 4,
  parameter int IDX_W    = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  data_t            err,
  input  preact_t          pre_act,
  input  logic             x_valid,
  output logic             x_ready,
  input  data_t            x,
  input  logic             w_ld_en,
  input  logic [IDX_W-1:0] w_ld_idx,
  input  data_t            w_ld_data,
  input  logic             b_ld_en,
  input  logic [IDX_W-1:0] w_rd_idx,
  output data_t            w_rd_data,
  output data_t            bias_out,
  output logic             upd_valid,
  output logic [IDX_W-1:0] upd_idx,
  output data_t            upd_w,
  output logic             done,
  output bp_state_e        state_dbg
);

  localparam logic [IDX_W:0]   N_CNT    = (IDX_W+1)'(N_INPUTS);
  localparam logic [IDX_W:0]   LAST_CNT = (IDX_W+1)'(N_INPUTS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);

  bp_state_e        state_q, state_d;
  data_t            w_q [N_INPUTS];
  data_t            bias_q;
  data_t            delta_q;
  logic [IDX_W:0]   cnt_q;
  logic             x_fire;
  logic [IDX_W-1:0] s1_idx;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  data_t            wr_data;
  data_t            bias_step;
  logic signed [16:0] bias_diff;

  assign start_ready = (state_q == IDLE);
  assign x_ready     = (state_q == GRAD) && (cnt_q < N_CNT);
  assign x_fire      = x_valid && x_ready;
  assign done        = (state_q == BIAS);
  assign w_rd_data   = w_q[w_rd_idx];
  assign bias_out    = bias_q;
  assign state_dbg   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_valid) state_d = GRAD;
      GRAD:    if (x_fire && (cnt_q == LAST_CNT)) state_d = DRAIN;
      // Leave once the last weight write is on the S2 write port.
      DRAIN:   if (wr_en && (wr_idx == LAST_IDX)) state_d = BIAS;
      BIAS:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bias_step = delta_q >>> LR_SHIFT;
    bias_diff = {{9{bias_q[7]}}, bias_q} - {{9{bias_step[7]}}, bias_step};
  end

  // Loads and pipeline writes never coincide: loads are IDLE-only and the
  // pipeline is empty by the time the sequencer returns to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delta_q <= '0;
      cnt_q   <= '0;
      bias_q  <= '0;
      for (int i = 0; i < N_INPUTS; i++) begin
        w_q[i] <= '0;
      end
    end else begin
      if ((state_q == IDLE) && start_valid) begin
        // ReLU derivative: non-positive pre-activation blocks the gradient.
        delta_q <= (pre_act > preact_t'(0)) ? err : '0;
        cnt_q   <= '0;
      end
      if (x_fire) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if ((state_q == IDLE) && w_ld_en) begin
        w_q[w_ld_idx] <= w_ld_data;
      end
      if (wr_en) begin
        w_q[wr_idx] <= wr_data;
      end
      if ((state_q == IDLE) && b_ld_en) begin
        bias_q <= w_ld_data;
      end else if (state_q == BIAS) begin
        bias_q <= sat8(bias_diff);
      end
    end
  end

  grad_step #(
    .IDX_W    (IDX_W),
    .LR_SHIFT (LR_SHIFT)
  ) u_grad_step (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (x_fire),
    .in_idx    (cnt_q[IDX_W-1:0]),
    .delta     (delta_q),
    .x         (x),
    .s1_idx    (s1_idx),
    .w_cur     (w_q[s1_idx]),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .upd_valid (upd_valid),
    .upd_idx   (upd_idx),
    .upd_w     (upd_w)
  );

endmodule

// File: tb/tb_neuron_backprop.sv
module tb_neuron_backprop;
  import neuron_pkg::*;

  localparam int N  = 4;
  localparam int LR = 4;
  localparam int M_IDLE = 0;
  localparam int M_GRAD = 1;
  localparam int M_WAIT = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start_valid = 1'b0;
  logic              start_ready;
  logic signed [7:0] err = '0;
  logic signed [17:0] pre_act = '0;
  logic              x_valid = 1'b0;
  logic              x_ready;
  logic signed [7:0] x = '0;
  logic              w_ld_en = 1'b0;
  logic [1:0]        w_ld_idx = '0;
  logic signed [7:0] w_ld_data = '0;
  logic              b_ld_en = 1'b0;
  logic [1:0]        w_rd_idx = '0;
  data_t             w_rd_data;
  data_t             bias_out;
  logic              upd_valid;
  logic [1:0]        upd_idx;
  data_t             upd_w;
  logic              done;
  bp_state_e         state_dbg;

  neuron_backprop #(.N_INPUTS(N), .LR_SHIFT(LR)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .err         (err),
    .pre_act     (pre_act),
    .x_valid     (x_valid),
    .x_ready     (x_ready),
    .x           (x),
    .w_ld_en     (w_ld_en),
    .w_ld_idx    (w_ld_idx),
    .w_ld_data   (w_ld_data),
    .b_ld_en     (b_ld_en),
    .w_rd_idx    (w_rd_idx),
    .w_rd_data   (w_rd_data),
    .bias_out    (bias_out),
    .upd_valid   (upd_valid),
    .upd_idx     (upd_idx),
    .upd_w       (upd_w),
    .done        (done),
    .state_dbg   (state_dbg)
  );

  // ---------------- counters / check helpers ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  function automatic int clamp8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // ---------------- behavioural model ----------------
  // Scoreboard entry: {due cycle[31:0], index[1:0], new weight[7:0]}
  logic [41:0] exp_q[$];
  int m_phase = M_IDLE;
  int m_cnt   = 0;
  int m_delta = 0;
  int m_w[N]  = '{0, 0, 0, 0};
  int m_bias  = 0;
  int pc      = 0;
  int m_done_pc = 0;
  int m_nw;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = M_IDLE;
      m_cnt   = 0;
      m_delta = 0;
      m_bias  = 0;
      for (int i = 0; i < N; i++) m_w[i] = 0;
      exp_q.delete();
    end else begin
      pc++;
      case (m_phase)
        M_IDLE: begin
          if (w_ld_en) m_w[w_ld_idx] = w_ld_data;
          if (b_ld_en) m_bias = w_ld_data;
          if (start_valid) begin
            m_delta = (pre_act > 0) ? int'(err) : 0;
            m_cnt   = 0;
            m_phase = M_GRAD;
          end
        end
        M_GRAD: begin
          if (x_valid) begin
            m_nw = clamp8(m_w[m_cnt] - ((m_delta * int'(x)) >>> LR));
            m_w[m_cnt] = m_nw;
            exp_q.push_back({32'(pc + 1), 2'(m_cnt), 8'(m_nw)});
            m_cnt++;
            if (m_cnt == N) begin
              m_phase   = M_WAIT;
              m_done_pc = pc + 1;
            end
          end
        end
        default: begin
          if (pc == m_done_pc + 1) begin
            m_bias  = clamp8(m_bias - (m_delta >>> LR));
            m_phase = M_IDLE;
          end
        end
      endcase
    end
  end

  // ---------------- compare process ----------------
  logic [41:0] head;
  bit          exp_upd;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("start_ready", start_ready, m_phase == M_IDLE);
      check("x_ready", x_ready, m_phase == M_GRAD);
      check("done", done, (m_phase == M_WAIT) && (pc == m_done_pc));
      exp_upd = (exp_q.size() > 0) && (exp_q[0][41:10] == pc);
      check("upd_valid", upd_valid, exp_upd);
      if (exp_upd) begin
        head = exp_q.pop_front();
        if (upd_valid) begin
          check("upd_idx", upd_idx, head[9:8]);
          check("upd_w", upd_w, $signed(head[7:0]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_w(input int idx, input int v);
    w_ld_en = 1'b1;
    w_ld_idx = 2'(idx);
    w_ld_data = 8'(v);
    tick();
    w_ld_en = 1'b0;
  endtask

  task automatic load_b(input int v);
    b_ld_en = 1'b1;
    w_ld_data = 8'(v);
    tick();
    b_ld_en = 1'b0;
  endtask

  task automatic start_op(input int e, input int p);
    int k;
    k = 0;
    while (!start_ready && k < 20) begin
      tick();
      k++;
    end
    if (k == 20) fail_timeout("start_wait");
    start_valid = 1'b1;
    err = 8'(e);
    pre_act = 18'(p);
    tick();
    start_valid = 1'b0;
    w_ld_en = 1'b0;
    b_ld_en = 1'b0;
  endtask

  task automatic send_beats(input int v0, input int v1, input int v2, input int v3,
                            input bit stall, input bit ld_mid);
    int vals[4];
    int k;
    vals = '{v0, v1, v2, v3};
    for (int i = 0; i < 4; i++) begin
      x_valid = 1'b1;
      x = 8'(vals[i]);
      k = 0;
      while (!x_ready && k < 20) begin
        tick();
        k++;
      end
      if (k == 20) fail_timeout("beat_wait");
      tick();
      x_valid = 1'b0;
      if (stall) begin
        if (ld_mid && i == 1) begin
          w_ld_en = 1'b1;
          b_ld_en = 1'b1;
          w_ld_idx = 2'd0;
          w_ld_data = 8'sd99;
        end
        tick();
        w_ld_en = 1'b0;
        b_ld_en = 1'b0;
      end
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 20) begin
      tick();
      k++;
    end
    if (k == 20) fail_timeout("done_wait");
    tick();
  endtask

  // Reads every weight and the bias; pins both DUT and model to literals.
  task automatic check_lits(input int e0, input int e1, input int e2, input int e3,
                            input int eb);
    int ev[4];
    ev = '{e0, e1, e2, e3};
    for (int i = 0; i < 4; i++) begin
      w_rd_idx = 2'(i);
      #1;
      check($sformatf("w_rd%0d", i), w_rd_data, ev[i]);
      check($sformatf("model_w%0d", i), m_w[i], ev[i]);
    end
    check("bias_out", bias_out, eb);
    check("model_bias", m_bias, eb);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_upd_valid", upd_valid, 0);
    check("rst_done", done, 0);
    check("rst_x_ready", x_ready, 0);
    check("rst_start_ready", start_ready, 1);
    check("rst_upd_idx", upd_idx, 0);
    check("rst_upd_w", upd_w, 0);
    check("rst_state_idle", state_dbg == IDLE, 1);
    check_lits(0, 0, 0, 0, 0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Basic step; last preload shares the cycle with the start.
    load_w(0, 10);
    load_w(1, 10);
    load_w(2, 10);
    load_b(0);
    w_ld_en = 1'b1;
    w_ld_idx = 2'd3;
    w_ld_data = 8'sd10;
    start_op(16, 5);
    send_beats(4, 0, -4, 1, 1'b0, 1'b0);
    wait_done();
    check_lits(6, 10, 14, 9, -1);

    // Gated by zero and negative pre-activation.
    start_op(100, 0);
    send_beats(50, -50, 127, -128, 1'b0, 1'b0);
    wait_done();
    check_lits(6, 10, 14, 9, -1);
    start_op(100, -7);
    send_beats(50, -50, 127, -128, 1'b0, 1'b0);
    wait_done();
    check_lits(6, 10, 14, 9, -1);

    // Saturation low then high.
    load_w(0, -120);
    load_w(1, 120);
    load_w(2, 0);
    load_w(3, 0);
    load_b(0);
    start_op(127, 1);
    send_beats(127, 0, 0, 0, 1'b0, 1'b0);
    wait_done();
    check_lits(-128, 120, 0, 0, -7);
    start_op(-128, 1);
    send_beats(0, 127, 0, 0, 1'b0, 1'b0);
    wait_done();
    check_lits(-128, 127, 0, 0, 1);

    // Floor rounding of a negative step.
    load_w(0, 5);
    load_b(0);
    start_op(-1, 3);
    send_beats(1, 0, 0, 0, 1'b0, 1'b0);
    wait_done();
    check_lits(6, 127, 0, 0, 1);

    // Stalled beats with loads attempted mid-update.
    load_w(0, 1);
    load_w(1, 2);
    load_w(2, 3);
    load_w(3, 4);
    load_b(0);
    start_op(32, 100);
    send_beats(16, -16, 8, 127, 1'b1, 1'b1);
    wait_done();
    check_lits(-31, 34, -13, -128, -2);

    // Reset in the middle of an update.
    load_w(0, 7);
    load_w(1, 7);
    load_w(2, 7);
    load_w(3, 7);
    load_b(3);
    start_op(16, 1);
    x_valid = 1'b1;
    x = 8'sd16;
    tick();
    tick();
    x_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_upd_valid", upd_valid, 0);
    check("mid_rst_upd_w", upd_w, 0);
    check("mid_rst_upd_idx", upd_idx, 0);
    check("mid_rst_start_ready", start_ready, 1);
    check_lits(0, 0, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    start_op(16, 1);
    send_beats(16, 16, 16, 16, 1'b0, 1'b0);
    wait_done();
    check_lits(-16, -16, -16, -16, -1);

    tick();
    tick();
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/neuron_backprop.md
Name: neuron_backprop

Overview:
Training-direction counterpart of the pipelined forward neuron. It owns the neuron's N_INPUTS signed 8-bit weights and bias and serves them to the forward path. It accepts one error sample plus the matching forward pre-activation, then consumes that sample's input vector. It applies a ReLU-derivative-gated, shift-scaled gradient step to every weight and then to the bias, with saturation.

Parameters:
N_INPUTS, 4, number of weights held; index width IDX_W = $clog2(N_INPUTS), min 1
LR_SHIFT, 4, learning rate as arithmetic right shift of the gradient (0..15)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  error sample offered
start_ready  output  1  high only in IDLE
err  input  8  signed output error for the sample
pre_act  input  18  signed forward pre-activation (bias-added sum) for the sample
x_valid  input  1  input-vector beat offered
x_ready  output  1  beat accepted when x_valid && x_ready
x  input  8  signed input value, beats in index order 0..N_INPUTS-1
w_ld_en  input  1  preload weight (honoured only in IDLE)
w_ld_idx  input  IDX_W  preload index
w_ld_data  input  8  signed preload value
b_ld_en  input  1  preload bias with w_ld_data (IDLE only)
w_rd_idx  input  IDX_W  combinational weight read index
w_rd_data  output  8  signed weight[w_rd_idx]
bias_out  output  8  signed current bias
upd_valid  output  1  one-cycle pulse per committed weight update
upd_idx  output  IDX_W  index written
upd_w  output  8  signed new weight value
done  output  1  one-cycle pulse when the bias update commits

Behaviour:
- Reset (async, any state): FSM to IDLE. All weights, bias, counters and pipeline registers clear to 0. upd_valid, done, x_ready and upd_idx go to 0; upd_w goes to 0. start_ready goes to 1. Reset during an update discards it; there is no partial recovery.
- FSM states are IDLE, GRAD, DRAIN and BIAS.
- IDLE: on start_valid, register delta = (pre_act > 0) ? err : 0. Zero or negative pre_act gives delta 0. Clear the beat counter and go to GRAD.
- Loads in IDLE: w_ld_en/b_ld_en write that same cycle. If a load and a start happen in the same cycle, the load is applied and the start is still accepted.
- GRAD: x_ready = 1 while beat count < N_INPUTS. Each accepted beat i runs through a two-stage pipeline:
  - S1 registers prod = delta * x (16-bit signed) and index i.
  - S2 computes step = prod >>> LR_SHIFT (floor, so -1 >>> 4 = -1) and w_new = sat8(w[i] - step), with the subtraction done in 17 bits and clamped to [-128, 127]. It writes w[i] and pulses upd_valid/upd_idx/upd_w.
  - Update appears 2 cycles after acceptance.
  - Stalls (x_valid low) insert bubbles only.
  - After beat N_INPUTS-1 is accepted, go to DRAIN.
- DRAIN: x_ready = 0. Wait until the S2 write for the last beat commits, then go to BIAS.
- BIAS (1 cycle): bias = sat8(bias - (delta >>> LR_SHIFT)), pulse done, return to IDLE. start_ready is high again the next cycle.
- When delta = 0, every index still pulses upd_valid with an unchanged value, and done still pulses.
- Indices are distinct, so there is no read-after-write hazard. w_rd_data reflects a write from the cycle after it commits.
- Loads outside IDLE are ignored. Beats offered in IDLE/DRAIN/BIAS are not accepted.

Decomposition:
- Package neuron_pkg holds:
  - typedefs data_t (signed 8), preact_t (signed 18), prod_t (signed 16);
  - state enum bp_state_e;
  - function sat8 (17-bit signed to 8-bit signed clamp).
- One sub-module, grad_step: the S1/S2 multiply, shift and saturate pipeline with valid and index carried alongside.
- The FSM, weight register file and bias stay in neuron_backprop.

Test Plan:
- Preload w[0..3] = 10, bias = 0; start err=16, pre_act=5; x = 4,0,-4,1 back-to-back -> upd_w = 6,10,14,9 at idx 0..3, each 2 cycles after acceptance; done with bias_out = -1 (wait: 16>>>4 = 1, so bias = -1).
- pre_act = 0 (and separately -7), err = 100 -> four upd_valid pulses with unchanged weights; bias unchanged; done pulses.
- Saturation: w0 = -120, err = 127, pre_act = 1, x0 = 127 -> step 1008, upd_w = -128. Also w1 = 120, err = -128, x1 = 127 -> upd_w = 127.
- Floor rounding: w0 = 5, err = -1, pre_act = 3, x0 = 1 -> step -1, upd_w = 6; bias 0 -> 1.
- x_valid toggled every other cycle, with w_ld_en asserted mid-GRAD -> loads ignored; updates are in order and spaced by the stalls; start_ready stays low until the cycle after done.
- Assert rst_n low in GRAD after 2 beats -> all weights, bias and outputs read 0 immediately, no further upd_valid; a new start is accepted after release.
